wb_ctrl_regs: RTL and testbench
===============================

WB_CTRL_REGS -- requirements
Module: wb_ctrl_regs

Interface
REQ-001 Parameter BASE_ADDRESS, default 32'h3000_0000, byte address of the register window.
REQ-002 Parameter CLOCK_WIDTH, default 6, width of clock_sel_o, range 1..16.
REQ-003 Parameter NUM_SCRATCH, default 4, number of 32-bit scratch registers, range 1..8.
REQ-004 Parameter NUM_IRQ, default 3, number of interrupt sources and lines, range 1..8.
REQ-005 Parameter VAL_WIDTH, default 30, width of the monitored value input, range 1..32.
REQ-006 The block SHALL have one clock, wb_clk_i; reset wb_rst_i is synchronous and active-high.
REQ-007 Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
wbs_stb_i  in  1  strobe
wbs_cyc_i  in  1  cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte lane select
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
irq_src_i  in  NUM_IRQ  interrupt sources, rising-edge sensitive
val_i  in  VAL_WIDTH  monitored value
irq_o  out  NUM_IRQ  interrupt lines
switch_o  out  1  enable for the downstream generator
clock_sel_o  out  CLOCK_WIDTH  clock divider select
panic_o  out  1  sticky panic flag

Function
REQ-008 The window SHALL be BASE_ADDRESS..BASE_ADDRESS+0xFF; adr[1:0] ignored; out-of-window requests never acked, and no state changes.
REQ-009 Register map (offset, access): 0x00 NR RO = 8+NUM_SCRATCH; 0x04 ID RO = 32'h4669626f; 0x08 CTRL RW, bit0 switch, bits[8+:CLOCK_WIDTH] clock_sel; 0x0C IRQ_STATUS RW1C; 0x10 IRQ_ENABLE RW; 0x14 IRQ_FORCE WO, reads 0; 0x18 VAL RO, zero-extended val_i; 0x1C PANIC, any write sets bit0; 0x20+4*i SCRATCH[i] RW.
REQ-010 Unmapped in-window offsets SHALL be acked, read 0, ignore writes.
REQ-011 Ack SHALL be registered: asserted for exactly one cycle, the cycle after stb&cyc is sampled in-window with ack low; never asserted two consecutive cycles.
REQ-012 Writes SHALL commit on the edge that raises ack; byte lanes with wbs_sel_i[k]=0 are unchanged for CTRL, IRQ_ENABLE, SCRATCH; W1C/FORCE/PANIC use lane 0 only.
REQ-013 wbs_dat_o SHALL carry read data registered on the edge that raises ack and SHALL be 0 whenever ack is low.
REQ-014 VAL SHALL return val_i sampled on the edge that raises ack.
REQ-015 A source rising edge (irq_src_i 0 in previous cycle, 1 now) SHALL set its IRQ_STATUS bit on the next edge.
REQ-016 IRQ_FORCE bit=1 SHALL set the matching IRQ_STATUS bit on the write edge.
REQ-017 Simultaneous set (edge or force) and W1C on the same bit: set wins.
REQ-018 irq_o SHALL be registered IRQ_STATUS & IRQ_ENABLE, one cycle after status update.
REQ-019 panic_o SHALL remain 1 until reset; PANIC write also forces switch to 0.
REQ-020 switch_o and clock_sel_o SHALL be driven directly from CTRL flops.
REQ-021 A request abandoned (stb or cyc low) before ack SHALL leave no side effects.

Reset
REQ-022 On wb_rst_i: ack 0, dat_o 0, IRQ_STATUS 0, IRQ_ENABLE 0, irq_o 0, edge-detect history 0, panic 0, switch 1, clock_sel 1, SCRATCH all 32'hf00df00d.
REQ-023 Reset asserted mid-transaction SHALL drop ack the next edge and discard the pending write.

Structure
REQ-024 Register offsets, ID constant and scratch reset value SHALL live in shared package wb_ctrl_pkg.
REQ-025 The IRQ status/enable/edge-detect logic SHALL be one sub-module, wb_irq_ctrl, parametrised by NUM_IRQ.

Verification
REQ-026 Read 0x04 after reset -> one-cycle ack, dat_o 32'h4669626f; read 0x00 with NUM_SCRATCH=4 -> 12.
REQ-027 Write SCRATCH[2] 32'h12345678 sel 4'b0101 after reset -> read 32'hf034f078.
REQ-028 Pulse irq_src_i[1], enable 3'b010 -> irq_o 3'b010; write 0x0C 32'h2 in the same cycle as a new edge -> bit stays set.
REQ-029 Access BASE_ADDRESS+0x100 and BASE_ADDRESS-4 held 4 cycles -> ack never asserted, no register change.
REQ-030 Write PANIC 32'h1 -> panic_o 1, switch_o 0; CTRL write bit0=1 -> switch_o 1, panic_o still 1 until wb_rst_i.
REQ-031 Assert wb_rst_i the cycle a CTRL write is sampled -> ack 0, clock_sel_o 1, switch_o 1.

Source files
------------

// File: rtl/wb_ctrl_pkg.sv
// rtl/wb_ctrl_pkg.sv - shared register map constants and helpers for wb_ctrl_regs
package wb_ctrl_pkg;

  localparam logic [7:0] OFF_NR         = 8'h00;
  localparam logic [7:0] OFF_ID         = 8'h04;
  localparam logic [7:0] OFF_CTRL       = 8'h08;
  localparam logic [7:0] OFF_IRQ_STATUS = 8'h0C;
  localparam logic [7:0] OFF_IRQ_ENABLE = 8'h10;
  localparam logic [7:0] OFF_IRQ_FORCE  = 8'h14;
  localparam logic [7:0] OFF_VAL        = 8'h18;
  localparam logic [7:0] OFF_PANIC      = 8'h1C;
  localparam logic [7:0] OFF_SCRATCH    = 8'h20;

  localparam logic [31:0] ID_VALUE    = 32'h4669626f;
  localparam logic [31:0] SCRATCH_RST = 32'hf00df00d;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int k = 0; k < 4; k++) begin
      res[8*k +: 8] = sel[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_irq_ctrl.sv
// rtl/wb_irq_ctrl.sv - interrupt edge detect, status, enable and registered irq lines
module wb_irq_ctrl #(
  parameter int NUM_IRQ = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_IRQ-1:0] src_i,
  input  logic [NUM_IRQ-1:0] set_i,
  input  logic [NUM_IRQ-1:0] clr_i,
  input  logic               en_we_i,
  input  logic [NUM_IRQ-1:0] en_wdata_i,
  output logic [NUM_IRQ-1:0] status_o,
  output logic [NUM_IRQ-1:0] enable_o,
  output logic [NUM_IRQ-1:0] irq_o
);

  logic [NUM_IRQ-1:0] hist_q;
  logic [NUM_IRQ-1:0] status_q, status_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] irq_q;

  // Setting sources are OR-ed in after the clear so a coincident set wins.
  always_comb begin
    status_d = (status_q & ~clr_i) | (src_i & ~hist_q) | set_i;
    enable_d = en_we_i ? en_wdata_i : enable_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q   <= '0;
      status_q <= '0;
      enable_q <= '0;
      irq_q    <= '0;
    end else begin
      hist_q   <= src_i;
      status_q <= status_d;
      enable_q <= enable_d;
      irq_q    <= status_q & enable_q;
    end
  end

  assign status_o = status_q;
  assign enable_o = enable_q;
  assign irq_o    = irq_q;

endmodule

// File: rtl/wb_ctrl_regs.sv
// rtl/wb_ctrl_regs.sv - Wishbone control/status register block with irq, panic and scratch
module wb_ctrl_regs
  import wb_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int          CLOCK_WIDTH  = 6,
  parameter int          NUM_SCRATCH  = 4,
  parameter int          NUM_IRQ      = 3,
  parameter int          VAL_WIDTH    = 30
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  input  logic [NUM_IRQ-1:0]     irq_src_i,
  input  logic [VAL_WIDTH-1:0]   val_i,
  output logic [NUM_IRQ-1:0]     irq_o,
  output logic                   switch_o,
  output logic [CLOCK_WIDTH-1:0] clock_sel_o,
  output logic                   panic_o
);

  logic [31:0] off;
  logic [7:0]  off_w;
  logic        in_win, fire, wr;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d, rdata;
  logic        switch_q, panic_q;
  logic [CLOCK_WIDTH-1:0] clock_sel_q, clock_sel_new;
  logic [31:0] scratch_q [NUM_SCRATCH];
  logic [NUM_IRQ-1:0] irq_status, irq_enable, irq_set, irq_clr;
  logic        irq_en_we;

  // Unsigned offset from the base: anything below the base wraps high and falls out.
  assign off    = wbs_adr_i - BASE_ADDRESS;
  assign in_win = (off[31:8] == 24'h0);
  assign off_w  = off[7:0] & 8'hFC;
  assign fire   = wbs_stb_i & wbs_cyc_i & in_win & ~ack_q;
  assign wr     = fire & wbs_we_i;

  assign irq_set   = (wr && off_w == OFF_IRQ_FORCE && wbs_sel_i[0]) ? wbs_dat_i[NUM_IRQ-1:0] : '0;
  assign irq_clr   = (wr && off_w == OFF_IRQ_STATUS && wbs_sel_i[0]) ? wbs_dat_i[NUM_IRQ-1:0] : '0;
  assign irq_en_we = wr && off_w == OFF_IRQ_ENABLE && wbs_sel_i[0];

  wb_irq_ctrl #(
    .NUM_IRQ(NUM_IRQ)
  ) u_irq (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .src_i      (irq_src_i),
    .set_i      (irq_set),
    .clr_i      (irq_clr),
    .en_we_i    (irq_en_we),
    .en_wdata_i (wbs_dat_i[NUM_IRQ-1:0]),
    .status_o   (irq_status),
    .enable_o   (irq_enable),
    .irq_o      (irq_o)
  );

  // clock_sel starts at CTRL bit 8, so each bit picks its own byte lane.
  always_comb begin
    clock_sel_new = clock_sel_q;
    for (int j = 0; j < CLOCK_WIDTH; j++) begin
      if (wbs_sel_i[(8 + j) / 8]) clock_sel_new[j] = wbs_dat_i[8 + j];
    end
  end

  always_comb begin
    rdata = '0;
    case (off_w)
      OFF_NR:         rdata = 32'(8 + NUM_SCRATCH);
      OFF_ID:         rdata = ID_VALUE;
      OFF_CTRL: begin
        rdata[0]                 = switch_q;
        rdata[8 +: CLOCK_WIDTH]  = clock_sel_q;
      end
      OFF_IRQ_STATUS: rdata = 32'(irq_status);
      OFF_IRQ_ENABLE: rdata = 32'(irq_enable);
      OFF_VAL:        rdata = 32'(val_i);
      OFF_PANIC:      rdata = {31'h0, panic_q};
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (off_w == OFF_SCRATCH + 8'(4 * i)) rdata = scratch_q[i];
        end
      end
    endcase
  end

  always_comb begin
    ack_d = fire;
    dat_d = (fire && !wbs_we_i) ? rdata : '0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      switch_q    <= 1'b1;
      clock_sel_q <= CLOCK_WIDTH'(1);
      panic_q     <= 1'b0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      if (wr && off_w == OFF_PANIC) begin
        panic_q  <= 1'b1;
        switch_q <= 1'b0;
      end else if (wr && off_w == OFF_CTRL) begin
        if (wbs_sel_i[0]) switch_q <= wbs_dat_i[0];
        clock_sel_q <= clock_sel_new;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (wb_rst_i) begin
        scratch_q[i] <= SCRATCH_RST;
      end else if (wr && off_w == OFF_SCRATCH + 8'(4 * i)) begin
        scratch_q[i] <= byte_merge(scratch_q[i], wbs_dat_i, wbs_sel_i);
      end
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign switch_o    = switch_q;
  assign clock_sel_o = clock_sel_q;
  assign panic_o     = panic_q;

endmodule

// File: tb/tb_wb_ctrl_regs.sv
// tb/tb_wb_ctrl_regs.sv - self-checking bench for wb_ctrl_regs
module tb_wb_ctrl_regs;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst, stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [2:0]  irq_src, irq;
  logic [29:0] val;
  logic        sw, panic;
  logic [5:0]  csel;

  always #5 clk = ~clk;

  wb_ctrl_regs #(
    .BASE_ADDRESS(BASE),
    .CLOCK_WIDTH (6),
    .NUM_SCRATCH (4),
    .NUM_IRQ     (3),
    .VAL_WIDTH   (30)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (wdat),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat),
    .irq_src_i   (irq_src),
    .val_i       (val),
    .irq_o       (irq),
    .switch_o    (sw),
    .clock_sel_o (csel),
    .panic_o     (panic)
  );

  typedef struct {
    logic        we;
    logic [7:0]  off;
    logic [31:0] wd;
    logic [3:0]  sel;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  logic [2:0]  src_drive = 3'b000;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic [7:0] off, input logic [31:0] wd,
                      input logic [3:0] s, input logic [31:0] exp, input string name);
    logic [31:0] got;
    logic [31:0] e;
    int lat;
    if (!w) exp_q.push_back(exp);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = BASE + {24'h0, off}; wdat = wd; sel = s;
    irq_src = src_drive;
    lat = 0;
    got = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (ack) begin
        lat = c;
        got = rdat;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    check({name, "_lat"}, 32'(lat), 32'd1);
    if (!w && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(name, got, e);
    end
  endtask

  task automatic hold_req(input logic [31:0] a, input logic c, input string name);
    int acks;
    acks = 0;
    @(negedge clk);
    stb = 1'b1; cyc = c; we = 1'b1; adr = a; wdat = 32'hBADC0DE5; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    check(name, 32'(acks), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] pat;
    logic [31:0] idle_dat;

    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
    adr = '0; wdat = '0; irq_src = 3'b000; val = 30'h2ABCDEF1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_ack",    32'(ack),  32'd0);
    check("rst_dat",    rdat,      32'd0);
    check("rst_irq",    32'(irq),  32'd0);
    check("rst_switch", 32'(sw),   32'd1);
    check("rst_csel",   32'(csel), 32'd1);
    check("rst_panic",  32'(panic), 32'd0);

    vecs.push_back('{1'b0, 8'h04, 32'h0,        4'hF, 32'h4669626f, "id"});
    vecs.push_back('{1'b0, 8'h00, 32'h0,        4'hF, 32'd12,       "nr"});
    vecs.push_back('{1'b0, 8'h07, 32'h0,        4'hF, 32'h4669626f, "adr_lsb_ignored"});
    vecs.push_back('{1'b0, 8'h08, 32'h0,        4'hF, 32'h00000101, "ctrl_rst"});
    vecs.push_back('{1'b0, 8'h20, 32'h0,        4'hF, 32'hf00df00d, "scr0_rst"});
    vecs.push_back('{1'b1, 8'h28, 32'h12345678, 4'h5, 32'h0,        "scr2_wr"});
    vecs.push_back('{1'b0, 8'h28, 32'h0,        4'hF, 32'hf034f078, "scr2_merge"});
    vecs.push_back('{1'b1, 8'h08, 32'h00002A00, 4'h2, 32'h0,        "ctrl_wr_lane1"});
    vecs.push_back('{1'b0, 8'h08, 32'h0,        4'hF, 32'h00002A01, "ctrl_lane1"});
    vecs.push_back('{1'b1, 8'h08, 32'hFFFFFF00, 4'h2, 32'h0,        "ctrl_wr_wide"});
    vecs.push_back('{1'b0, 8'h08, 32'h0,        4'hF, 32'h00003F01, "ctrl_csel_width"});
    vecs.push_back('{1'b0, 8'h0C, 32'h0,        4'hF, 32'h0,        "status_rst"});
    vecs.push_back('{1'b0, 8'h10, 32'h0,        4'hF, 32'h0,        "enable_rst"});
    vecs.push_back('{1'b1, 8'h10, 32'hFFFFFFFF, 4'hE, 32'h0,        "enable_wr_nolane0"});
    vecs.push_back('{1'b0, 8'h10, 32'h0,        4'hF, 32'h0,        "enable_lane0_kept"});
    vecs.push_back('{1'b0, 8'h14, 32'h0,        4'hF, 32'h0,        "force_reads0"});
    vecs.push_back('{1'b0, 8'h18, 32'h0,        4'hF, 32'h2ABCDEF1, "val"});
    vecs.push_back('{1'b0, 8'h1C, 32'h0,        4'hF, 32'h0,        "panic_rd_rst"});
    vecs.push_back('{1'b1, 8'h40, 32'h55555555, 4'hF, 32'h0,        "unmapped_wr"});
    vecs.push_back('{1'b0, 8'h40, 32'h0,        4'hF, 32'h0,        "unmapped_rd"});
    vecs.push_back('{1'b0, 8'h30, 32'h0,        4'hF, 32'h0,        "scr4_absent"});
    vecs.push_back('{1'b1, 8'h04, 32'h0,        4'hF, 32'h0,        "id_wr"});
    vecs.push_back('{1'b0, 8'h04, 32'h0,        4'hF, 32'h4669626f, "id_ro"});
    vecs.push_back('{1'b1, 8'h2C, 32'hDEADBEEF, 4'hF, 32'h0,        "scr3_wr"});
    vecs.push_back('{1'b0, 8'h2C, 32'h0,        4'hF, 32'hDEADBEEF, "scr3_rd"});
    vecs.push_back('{1'b0, 8'h24, 32'h0,        4'hF, 32'hf00df00d, "scr1_rst"});

    foreach (vecs[i]) xfer(vecs[i].we, vecs[i].off, vecs[i].wd, vecs[i].sel, vecs[i].exp, vecs[i].name);
    check("csel_out", 32'(csel), 32'h3F);

    // Held read: ack must pulse and never stay high two cycles.
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h4; sel = 4'hF;
    pat = 4'b0;
    idle_dat = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat = {pat[2:0], ack};
      if (i == 1) idle_dat = rdat;
    end
    stb = 1'b0; cyc = 1'b0;
    check("ack_pattern", 32'(pat), 32'b1010);
    check("dat_zero_ack_low", idle_dat, 32'h0);

    hold_req(BASE + 32'h100, 1'b1, "oow_hi");
    hold_req(BASE + 32'h120, 1'b1, "oow_hi_alias");
    hold_req(BASE - 32'h4,   1'b1, "oow_lo");
    hold_req(BASE + 32'h20,  1'b0, "abandon_cyc_low");
    xfer(1'b0, 8'h20, 32'h0, 4'hF, 32'hf00df00d, "scr0_untouched");
    xfer(1'b0, 8'h1C, 32'h0, 4'hF, 32'h0,        "panic_untouched");

    xfer(1'b1, 8'h10, 32'h2, 4'hF, 32'h0, "enable_wr");
    @(negedge clk); irq_src = 3'b010;
    @(negedge clk); irq_src = 3'b000;
    @(negedge clk);
    check("irq_pulse", 32'(irq), 32'b010);
    xfer(1'b0, 8'h0C, 32'h0, 4'hF, 32'h2, "status_edge");
    src_drive = 3'b010;
    xfer(1'b1, 8'h0C, 32'h2, 4'hF, 32'h0, "w1c_vs_edge");
    xfer(1'b0, 8'h0C, 32'h0, 4'hF, 32'h2, "set_wins");
    xfer(1'b1, 8'h0C, 32'h2, 4'hF, 32'h0, "w1c");
    xfer(1'b0, 8'h0C, 32'h0, 4'hF, 32'h0, "status_cleared");
    src_drive = 3'b000;
    repeat (2) @(negedge clk);
    check("irq_cleared", 32'(irq), 32'b000);
    xfer(1'b1, 8'h14, 32'h5, 4'hF, 32'h0, "force_wr");
    xfer(1'b0, 8'h0C, 32'h0, 4'hF, 32'h5, "status_forced");
    check("irq_masked", 32'(irq), 32'b000);
    xfer(1'b1, 8'h10, 32'h7, 4'hF, 32'h0, "enable_all");
    repeat (2) @(negedge clk);
    check("irq_forced", 32'(irq), 32'b101);

    xfer(1'b1, 8'h1C, 32'h1, 4'hF, 32'h0, "panic_wr");
    check("panic_set",    32'(panic), 32'd1);
    check("panic_sw_off", 32'(sw),    32'd0);
    xfer(1'b1, 8'h08, 32'h1, 4'h1, 32'h0, "ctrl_sw_on");
    check("sw_back_on",   32'(sw),    32'd1);
    check("panic_sticky", 32'(panic), 32'd1);
    xfer(1'b0, 8'h1C, 32'h0, 4'hF, 32'h1, "panic_rd");

    // Reset lands on the same edge that samples a CTRL write.
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 32'h8; wdat = 32'h0; sel = 4'hF;
    rst = 1'b1;
    @(negedge clk);
    check("rstw_ack",    32'(ack),   32'd0);
    check("rstw_csel",   32'(csel),  32'd1);
    check("rstw_switch", 32'(sw),    32'd1);
    check("rstw_panic",  32'(panic), 32'd0);
    check("rstw_irq",    32'(irq),   32'd0);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    rst = 1'b0;
    xfer(1'b0, 8'h2C, 32'h0, 4'hF, 32'hf00df00d, "scr3_after_rst");
    xfer(1'b0, 8'h0C, 32'h0, 4'hF, 32'h0,        "status_after_rst");
    xfer(1'b0, 8'h08, 32'h0, 4'hF, 32'h00000101, "ctrl_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
